// File: rtl/regfile_unique0_pkg.sv
// -----------------------------------------------------------------------------
// regfile_unique0_pkg
// Purpose : Architectural constants shared by the register file, decode and the
//           forward unit (RV32I integer register file geometry).
// Contents: XLEN      - data width of one register
//           NREGS     - number of architectural registers (x0..x31)
//           REG_IDX_W - width of a register index
//           reg_idx_t / xdata_t - convenience types built on the above
// -----------------------------------------------------------------------------
package regfile_unique0_pkg;

   localparam int XLEN      = 32;
   localparam int NREGS     = 32;
   localparam int REG_IDX_W = 5;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]      xdata_t;

endpackage : regfile_unique0_pkg

// File: rtl/regfile_unique0.sv
// -----------------------------------------------------------------------------
// regfile_unique0
// Purpose : RV32I integer register file. 31 stored registers (x1..x31), x0 is
//           hardwired to zero. Two combinational read ports with a same-cycle
//           write-to-read bypass, one synchronous write port.
// Ports   : clk    in   1  core clock, state updates on rising edge
//           reset  in   1  asynchronous active-high clear of x1..x31
//           rs1    in   5  read port 1 index
//           rdata1 out 32  read port 1 data
//           rs2    in   5  read port 2 index
//           rdata2 out 32  read port 2 data
//           wreg   in   5  write index
//           wdata  in  32  write data
//           wen    in   1  write enable
// -----------------------------------------------------------------------------
module regfile_unique0
   import regfile_unique0_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [REG_IDX_W-1:0] rs1,
   output logic [XLEN-1:0]      rdata1,
   input  logic [REG_IDX_W-1:0] rs2,
   output logic [XLEN-1:0]      rdata2,
   input  logic [REG_IDX_W-1:0] wreg,
   input  logic [XLEN-1:0]      wdata,
   input  logic                 wen
);

   // Storage for x1..x31 only; x0 has no flops.
   xdata_t r_regs [1:NREGS-1];

   // A write that targets x0 is architecturally a no-op.
   logic w_wr_valid;
   assign w_wr_valid = wen && (wreg != '0);

   // NOTE: this array is small and built from flops, so it can take the
   // asynchronous clear; a RAM macro could not be reset like this.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 1; i < NREGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_valid) begin
         r_regs[wreg] <= wdata;
      end
   end

   // Read priority: x0 -> reset -> bypass -> stored array. The bypass supplies
   // writeback values that decode's forwarding network does not cover.
   function automatic xdata_t read_port(
      input reg_idx_t idx,
      input logic     rst,
      input logic     wr_valid,
      input reg_idx_t wr_idx,
      input xdata_t   wr_data,
      input xdata_t   stored
   );
      xdata_t result;
      if (idx == '0 || rst) begin
         result = '0;
      end else if (wr_valid && wr_idx == idx) begin
         result = wr_data;
      end else begin
         result = stored;
      end
      return result;
   endfunction

   // Stored values fetched separately so the x0 index never addresses the array.
   xdata_t w_stored1;
   xdata_t w_stored2;

   // NOTE: every always_comb output gets a default first so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      w_stored1 = '0;
      w_stored2 = '0;
      if (rs1 != '0) begin
         w_stored1 = r_regs[rs1];
      end
      if (rs2 != '0) begin
         w_stored2 = r_regs[rs2];
      end
   end

   assign rdata1 = read_port(rs1, reset, w_wr_valid, wreg, wdata, w_stored1);
   assign rdata2 = read_port(rs2, reset, w_wr_valid, wreg, wdata, w_stored2);

endmodule : regfile_unique0

// File: tb/tb_regfile_unique0.sv
// -----------------------------------------------------------------------------
// tb_regfile_unique0
// Purpose : Self-checking bench for regfile_unique0. Directed scenarios followed
//           by randomized traffic, all compared against a plain array model of
//           the architectural register state.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_regfile_unique0;

   logic        clk;
   logic        reset;
   logic [4:0]  rs1;
   logic [31:0] rdata1;
   logic [4:0]  rs2;
   logic [31:0] rdata2;
   logic [4:0]  wreg;
   logic [31:0] wdata;
   logic        wen;

   regfile_unique0 dut (
      .clk    (clk),
      .reset  (reset),
      .rs1    (rs1),
      .rdata1 (rdata1),
      .rs2    (rs2),
      .rdata2 (rdata2),
      .wreg   (wreg),
      .wdata  (wdata),
      .wen    (wen)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Architectural state: model[0] is never written and never consulted.
   logic [31:0] model [32];
   int n_pass  = 0;
   int n_total = 0;

   // What an architectural read of register idx returns right now.
   function automatic logic [31:0] expect_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'h0;
      if (reset)       return 32'h0;
      if (wen && wreg == idx) return wdata;
      return model[idx];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] a, input logic [4:0] b,
                        input logic we, input logic [4:0] wr, input logic [31:0] wd);
      rs1   = a;
      rs2   = b;
      wen   = we;
      wreg  = wr;
      wdata = wd;
   endtask

   // Compare both read ports against the model, 1 ns after inputs settle.
   task automatic check_ports(input string tag);
      #1;
      check({tag, "/rd1"}, rdata1, expect_read(rs1));
      check({tag, "/rd2"}, rdata2, expect_read(rs2));
   endtask

   // Advance one clock: commit the model at the rising edge, return at falling.
   task automatic tick();
      @(posedge clk);
      if (!reset && wen && wreg != 5'd0) model[wreg] = wdata;
      @(negedge clk);
   endtask

   task automatic clear_model();
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
   endtask

   initial begin
      clear_model();
      reset = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);

      // Reset state and writes ignored while reset is high (no bypass either).
      drive(5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
      check("reset_read", rdata1, 32'h0);
      check("reset_read31", rdata2, 32'h0);
      drive(5'd5, 5'd5, 1'b1, 5'd5, 32'hDEADBEEF);
      #1;
      check("reset_no_bypass", rdata1, 32'h0);
      tick();
      reset = 1'b0;
      drive(5'd5, 5'd31, 1'b0, 5'd0, 32'h0);
      #1;
      check("post_reset_x5", rdata1, 32'h0);
      check("post_reset_x31", rdata2, 32'h0);
      @(negedge clk);

      // Basic write then read.
      drive(5'd0, 5'd0, 1'b1, 5'd3, 32'h12345678);
      tick();
      drive(5'd3, 5'd4, 1'b0, 5'd0, 32'h0);
      #1;
      check("basic_x3", rdata1, 32'h12345678);
      check("basic_x4", rdata2, 32'h0);
      @(negedge clk);

      // x0 immunity in the write cycle and the next.
      drive(5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
      #1;
      check("x0_same_rd1", rdata1, 32'h0);
      check("x0_same_rd2", rdata2, 32'h0);
      tick();
      drive(5'd0, 5'd0, 1'b0, 5'd0, 32'h0);
      #1;
      check("x0_next_rd1", rdata1, 32'h0);
      check("x0_next_rd2", rdata2, 32'h0);
      @(negedge clk);

      // Same-cycle bypass, both ports on the same index.
      drive(5'd0, 5'd0, 1'b1, 5'd7, 32'h11);
      tick();
      drive(5'd7, 5'd7, 1'b1, 5'd7, 32'h22);
      #1;
      check("bypass_rd1", rdata1, 32'h22);
      check("bypass_rd2", rdata2, 32'h22);
      tick();
      drive(5'd7, 5'd7, 1'b0, 5'd0, 32'h0);
      #1;
      check("bypass_next_rd1", rdata1, 32'h22);
      check("bypass_next_rd2", rdata2, 32'h22);
      @(negedge clk);

      // Port independence: rs1 sees stored x1, rs2 sees bypassed x2.
      drive(5'd0, 5'd0, 1'b1, 5'd1, 32'hA);
      tick();
      drive(5'd0, 5'd0, 1'b1, 5'd2, 32'hB);
      tick();
      drive(5'd1, 5'd2, 1'b1, 5'd2, 32'hC);
      #1;
      check("indep_rd1", rdata1, 32'hA);
      check("indep_rd2", rdata2, 32'hC);
      tick();

      // Fill x1..x31 with index * 0x01010101 and read everything back.
      for (int i = 1; i < 32; i++) begin
         drive(5'd0, 5'd0, 1'b1, 5'(i), 32'(i) * 32'h01010101);
         tick();
      end
      for (int i = 1; i < 32; i += 2) begin
         drive(5'(i), 5'((i + 1) % 32), 1'b0, 5'd0, 32'h0);
         check_ports("fill_readback");
         @(negedge clk);
      end

      // Asynchronous reset between edges with a write pending in that cycle.
      drive(5'd9, 5'd31, 1'b1, 5'd12, 32'hCAFEF00D);
      #1;
      check("prereset_x9", rdata1, 32'h09090909);
      #1;
      reset = 1'b1;
      clear_model();
      #0.5;
      check("async_clr_x9", rdata1, 32'h0);
      check("async_clr_x31", rdata2, 32'h0);
      rs1 = 5'd12;
      rs2 = 5'd20;
      #0.5;
      check("async_clr_x12", rdata1, 32'h0);
      check("async_clr_x20", rdata2, 32'h0);
      tick();
      reset = 1'b0;
      drive(5'd12, 5'd9, 1'b0, 5'd0, 32'h0);
      check_ports("after_async_reset");
      @(negedge clk);

      // Randomized traffic with occasional reset pulses.
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic [4:0] wr_idx;
         wr_idx = 5'($urandom_range(0, 31));
         drive(5'($urandom_range(0, 31)),
               ($urandom_range(0, 3) == 0) ? wr_idx : 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)),
               wr_idx,
               $urandom());
         if ($urandom_range(0, 3) == 0) rs1 = wr_idx;
         if ($urandom_range(0, 39) == 0) begin
            reset = 1'b1;
            clear_model();
         end
         check_ports("random");
         tick();
         reset = 1'b0;
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_regfile_unique0
